// File: rtl/agc_rom_fetch_pkg.sv
// Shared widths, state encoding and timer sizing for the AGC ROM fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package agc_rom_fetch_pkg;

   localparam int ROM_ADDR_W = 17;
   localparam int ROM_DATA_W = 16;

   // Sequencer state encoding, kept as plain constants so older tools and
   // netlist probes see a fixed 3-bit code.
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SETUP   = 3'd1;
   localparam logic [2:0] ST_ACCESS  = 3'd2;
   localparam logic [2:0] ST_READ    = 3'd3;
   localparam logic [2:0] ST_RECOVER = 3'd4;
   localparam logic [2:0] ST_RESP    = 3'd5;

   // Counter width that can hold (max phase length - 1); never below 1 bit.
   function automatic int timer_w(input int acc, input int oe, input int rec);
      int m;
      m = acc;
      if (oe > m) m = oe;
      if (rec > m) m = rec;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/agc_rom_fetch_if.sv
// Request/response channel between the AGC core fetch path and the ROM sequencer.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the response side.
interface agc_rom_fetch_if;
   import agc_rom_fetch_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   logic [ROM_ADDR_W-1:0] req_addr;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ROM_DATA_W-1:0] rsp_data;

   // Core side: issues word addresses and consumes fetched words.
   modport master (
      output req_valid,
      output req_addr,
      output rsp_ready,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data
   );

   // Sequencer side: accepts addresses and returns fetched words.
   modport slave (
      input  req_valid,
      input  req_addr,
      input  rsp_ready,
      output req_ready,
      output rsp_valid,
      output rsp_data
   );

endinterface

// File: rtl/agc_rom_fetch_timer.sv
// Loadable down-counter with a zero flag, shared by the ACCESS/READ/RECOVER phases.
// Latency: a loaded value N reads back as zero N clocks after the load edge.
// Backpressure: none; load has priority over counting, counter parks at zero.
module agc_rom_fetch_timer #(
   parameter int W = 7
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: reload wins, otherwise step down until zero and hold there.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != '0) begin
         count_d = count_q - W'(1);
      end
   end

   // Counter register, cleared by reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/agc_rom_fetch.sv
// Read sequencer driving an SST39VF200A-style parallel flash for AGC ROM fetches.
// Latency: 1+ACCESS_CYCLES+OE_CYCLES+RECOVER_CYCLES+1 clocks handshake-to-rsp_valid; 1 clock on a cache hit.
// Backpressure: one request in flight; req_ready only in IDLE, response held until rsp_ready.
// Optional build macro: AGC_ROM_FETCH_CACHE_EN adds a one-entry last-word cache.
module agc_rom_fetch
   import agc_rom_fetch_pkg::*;
#(
   parameter int ACCESS_CYCLES  = 128,
   parameter int OE_CYCLES      = 2,
   parameter int RECOVER_CYCLES = 2
) (
   input  logic                  SIM_CLK,
   input  logic                  SIM_RST,
   agc_rom_fetch_if.slave        bus,
   output logic [ROM_ADDR_W-1:0] flash_a,
   output logic                  flash_ce_n,
   output logic                  flash_oe_n,
   output logic                  flash_we_n,
   input  logic [ROM_DATA_W-1:0] flash_dq,
   output logic                  busy
);

   // Zero-length phases would break the countdown scheme, so refuse them.
   if (ACCESS_CYCLES < 1) begin : g_bad_access
      $error("agc_rom_fetch: ACCESS_CYCLES must be >= 1");
   end
   if (OE_CYCLES < 1) begin : g_bad_oe
      $error("agc_rom_fetch: OE_CYCLES must be >= 1");
   end
   if (RECOVER_CYCLES < 1) begin : g_bad_recover
      $error("agc_rom_fetch: RECOVER_CYCLES must be >= 1");
   end

   localparam int TW = timer_w(ACCESS_CYCLES, OE_CYCLES, RECOVER_CYCLES);
   localparam logic [TW-1:0] LD_ACCESS  = TW'(ACCESS_CYCLES - 1);
   localparam logic [TW-1:0] LD_OE      = TW'(OE_CYCLES - 1);
   localparam logic [TW-1:0] LD_RECOVER = TW'(RECOVER_CYCLES - 1);

   logic [2:0]            state_q, state_d;
   logic [ROM_ADDR_W-1:0] flash_a_q, flash_a_d;
   logic                  ce_n_q, ce_n_d;
   logic                  oe_n_q, oe_n_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [ROM_DATA_W-1:0] rsp_data_q, rsp_data_d;

   logic                  tmr_load;
   logic [TW-1:0]         tmr_val;
   logic                  tmr_zero;

   logic                  req_hs;
   logic                  cache_hit;
   logic [ROM_DATA_W-1:0] cache_dat;

   agc_rom_fetch_timer #(
      .W (TW)
   ) u_timer (
      .clk_i      (SIM_CLK),
      .rst_n_i    (SIM_RST),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   // Ready is forced low while reset is asserted so nothing is taken during reset.
   assign bus.req_ready = (state_q == ST_IDLE) && SIM_RST;
   assign req_hs        = bus.req_valid && bus.req_ready;

`ifdef AGC_ROM_FETCH_CACHE_EN
   logic [ROM_ADDR_W-1:0] cache_tag_q;
   logic [ROM_DATA_W-1:0] cache_dat_q;
   logic                  cache_vld_q;
   logic                  cache_fill;

   // Every flash sample refreshes the cache with the word just read.
   assign cache_fill = (state_q == ST_READ) && tmr_zero;

   // Last-word cache storage, emptied by reset.
   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         cache_tag_q <= '0;
         cache_dat_q <= '0;
         cache_vld_q <= 1'b0;
      end else if (cache_fill) begin
         cache_tag_q <= flash_a_q;
         cache_dat_q <= flash_dq;
         cache_vld_q <= 1'b1;
      end
   end

   assign cache_hit = cache_vld_q && (cache_tag_q == bus.req_addr);
   assign cache_dat = cache_dat_q;
`else
   assign cache_hit = 1'b0;
   assign cache_dat = '0;
`endif

   // Sequencer next-state: walks the flash read cycle and manages the phase timer.
   always_comb begin
      state_d     = state_q;
      flash_a_d   = flash_a_q;
      ce_n_d      = ce_n_q;
      oe_n_d      = oe_n_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      tmr_load    = 1'b0;
      tmr_val     = '0;

      case (state_q)
         ST_IDLE: begin
            if (req_hs) begin
               if (cache_hit) begin
                  // Serve from the cache; flash pins stay untouched.
                  rsp_data_d  = cache_dat;
                  rsp_valid_d = 1'b1;
                  state_d     = ST_RESP;
               end else begin
                  flash_a_d = bus.req_addr;
                  state_d   = ST_SETUP;
               end
            end
         end
         ST_SETUP: begin
            ce_n_d   = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = LD_ACCESS;
            state_d  = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (tmr_zero) begin
               oe_n_d   = 1'b0;
               tmr_load = 1'b1;
               tmr_val  = LD_OE;
               state_d  = ST_READ;
            end
         end
         ST_READ: begin
            if (tmr_zero) begin
               // The only point where DQ is looked at; it is floating elsewhere.
               rsp_data_d = flash_dq;
               ce_n_d     = 1'b1;
               oe_n_d     = 1'b1;
               tmr_load   = 1'b1;
               tmr_val    = LD_RECOVER;
               state_d    = ST_RECOVER;
            end
         end
         ST_RECOVER: begin
            if (tmr_zero) begin
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            // Unreachable codes fall back to a quiet bus and IDLE.
            ce_n_d      = 1'b1;
            oe_n_d      = 1'b1;
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State and pin registers; reset drops CE_n/OE_n high without waiting for a clock.
   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         state_q     <= ST_IDLE;
         flash_a_q   <= '0;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         flash_a_q   <= flash_a_d;
         ce_n_q      <= ce_n_d;
         oe_n_q      <= oe_n_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign flash_a       = flash_a_q;
   assign flash_ce_n    = ce_n_q;
   assign flash_oe_n    = oe_n_q;
   assign flash_we_n    = 1'b1;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_agc_rom_fetch.sv
// Bench for agc_rom_fetch with a behavioural SST39VF200A read model behind the flash pins.
// Latency: checks handshake-to-response clock counts against the phase-length formula.
// Backpressure: exercises held responses, early rsp_ready and requests arriving while busy.
module tb_agc_rom_fetch;
   timeunit 1ns;
   timeprecision 100ps;

   localparam int A = 128;
   localparam int O = 2;
   localparam int R = 2;
   localparam int FULL_LAT = 1 + A + O + R + 1;
`ifdef AGC_ROM_FETCH_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   logic        SIM_CLK = 1'b0;
   logic        SIM_RST;
   logic [16:0] flash_a;
   logic        flash_ce_n, flash_oe_n, flash_we_n, busy;
   logic [15:0] flash_dq;
   logic [15:0] dq_q = 'z;
   logic [15:0] rom [0:131071];

   int          checks = 0;
   int          passes = 0;

   // reference model of the optional cache: last word fetched from flash
   logic [16:0] last_addr = '0;
   bit          last_vld  = 1'b0;

   // CE_n high-gap monitor
   bit          gap_clr = 1'b0;
   bit          seen_low = 1'b0;
   int          hi_run = 0;
   int          min_gap = 1000;

   agc_rom_fetch_if bus ();

   agc_rom_fetch #(
      .ACCESS_CYCLES  (A),
      .OE_CYCLES      (O),
      .RECOVER_CYCLES (R)
   ) dut (
      .SIM_CLK    (SIM_CLK),
      .SIM_RST    (SIM_RST),
      .bus        (bus),
      .flash_a    (flash_a),
      .flash_ce_n (flash_ce_n),
      .flash_oe_n (flash_oe_n),
      .flash_we_n (flash_we_n),
      .flash_dq   (flash_dq),
      .busy       (busy)
   );

   always #5 SIM_CLK = ~SIM_CLK;

   // Flash read model: DQ driven one clock after CE_n and OE_n are both low, floating otherwise.
   always @(posedge SIM_CLK) begin
      if (flash_ce_n === 1'b0 && flash_oe_n === 1'b0) dq_q <= rom[flash_a];
      else dq_q <= 'z;
   end
   assign flash_dq = dq_q;

   // Shortest CE_n-high stretch seen between two accesses since the last clear.
   always @(negedge SIM_CLK) begin
      if (gap_clr) begin
         seen_low = 1'b0;
         hi_run   = 0;
         min_gap  = 1000;
      end else if (flash_ce_n === 1'b1) begin
         hi_run++;
      end else begin
         if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
         hi_run   = 0;
         seen_low = 1'b1;
      end
   end

   initial begin
      #300us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge SIM_CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
   endtask

   // One complete fetch; hold = clocks rsp_ready stays low once rsp_valid is up,
   // early = rsp_ready already high while the access is in progress.
   task automatic do_read(input logic [16:0] addr, input int hold, input bit early);
      bit          hit;
      logic [15:0] exp_d;
      int          exp_lat, exp_ce, n, lat, ce_cnt;
      bit          bad_a, bad_rdy, bad_hold;
      hit     = CACHE && last_vld && (last_addr == addr);
      exp_d   = rom[addr];
      exp_lat = hit ? 1 : FULL_LAT;
      exp_ce  = hit ? 0 : A + O;

      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      bus.rsp_ready = early;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("req_ready_in_idle", {31'd0, bus.req_ready}, 32'd1);
      tick();
      // keep a different request pending while busy; it must be ignored
      bus.req_addr = addr ^ 17'h0A5A5;
      lat = 1; ce_cnt = 0; bad_a = 0; bad_rdy = 0;
      while (bus.rsp_valid !== 1'b1 && lat < 400) begin
         if (flash_ce_n === 1'b0) begin
            ce_cnt++;
            if (flash_a !== addr) bad_a = 1'b1;
         end
         if (bus.req_ready !== 1'b0) bad_rdy = 1'b1;
         tick();
         lat++;
      end
      chk("latency", lat, exp_lat);
      chk("rsp_data", {16'd0, bus.rsp_data}, {16'd0, exp_d});
      chk("ce_low_cycles", ce_cnt, exp_ce);
      chk("flash_a_stable", {31'd0, bad_a}, 32'd0);
      chk("req_ready_busy", {31'd0, bad_rdy}, 32'd0);

      if (!early) begin
         bad_hold = 1'b0;
         for (int i = 0; i < hold; i++) begin
            tick();
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d || bus.req_ready !== 1'b0)
               bad_hold = 1'b1;
         end
         if (hold > 0) chk("rsp_hold_stable", {31'd0, bad_hold}, 32'd0);
         bus.rsp_ready = 1'b1;
      end
      tick();
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b0;
      chk("rsp_valid_drop", {31'd0, bus.rsp_valid}, 32'd0);
      chk("idle_after_rsp", {31'd0, busy}, 32'd0);
      if (!hit) begin
         last_addr = addr;
         last_vld  = 1'b1;
      end
   endtask

   initial begin
      logic [16:0] ra;
      for (int i = 0; i < 131072; i++) rom[i] = 16'($urandom);

      // 1: reset with a request pending
      SIM_RST       = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_addr  = 17'h00155;
      bus.rsp_ready = 1'b0;
      repeat (3) tick();
      chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("rst_ce_n", {31'd0, flash_ce_n}, 32'd1);
      chk("rst_oe_n", {31'd0, flash_oe_n}, 32'd1);
      chk("rst_we_n", {31'd0, flash_we_n}, 32'd1);
      chk("rst_flash_a", {15'd0, flash_a}, 32'd0);
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      bus.req_valid = 1'b0;
      SIM_RST       = 1'b1;
      tick();
      chk("post_rst_idle", {31'd0, busy}, 32'd0);

      // 2: address 0, consumer always ready
      do_read(17'h00000, 0, 1'b1);

      // 3: top address, response held off for 20 clocks
      do_read(17'h1FFFF, 20, 1'b0);

      // 4: reset 60 clocks into ACCESS, then a fresh read
      bus.req_valid = 1'b1;
      bus.req_addr  = 17'h00100;
      chk("req_ready_before_abort", {31'd0, bus.req_ready}, 32'd1);
      tick();
      bus.req_valid = 1'b0;
      repeat (61) tick();
      chk("ce_low_in_access", {31'd0, flash_ce_n}, 32'd0);
      SIM_RST = 1'b0;
      #0.1;
      chk("abort_ce_n", {31'd0, flash_ce_n}, 32'd1);
      chk("abort_oe_n", {31'd0, flash_oe_n}, 32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      last_vld = 1'b0;
      repeat (3) tick();
      SIM_RST = 1'b1;
      tick();
      do_read(17'h00100, 2, 1'b0);

      // 5: back-to-back reads, CE_n must rest for the recovery time between them
      gap_clr = 1'b1;
      tick();
      gap_clr = 1'b0;
      do_read(17'h00010, 0, 1'b1);
      do_read(17'h00011, 0, 1'b1);
      chk("ce_recover_gap_ok", {31'd0, (min_gap >= R && min_gap < 1000)}, 32'd1);

      // 6: repeated address (cache hit when enabled), then the neighbour
      do_read(17'h00042, 0, 1'b1);
      do_read(17'h00042, 1, 1'b0);
      do_read(17'h00043, 0, 1'b1);

      // random addresses, some repeated, random consumer behaviour
      for (int k = 0; k < 10; k++) begin
         if ($urandom_range(0, 2) == 0 && last_vld) ra = last_addr;
         else ra = 17'($urandom);
         do_read(ra, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
